// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit datapath.
//   uart_packer_state_e   : receive word packer FSM states
//   uart_err_cnt_width_gp : width of the saturating error counters
package uart_pkg;

  typedef enum logic [0:0] {
    e_fill,
    e_stall
  } uart_packer_state_e;

  localparam int unsigned uart_err_cnt_width_gp = 8;

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   inc_i            : count up by one (held at all-ones once saturated)
//   clear_i          : synchronous clear to zero
//   count_o          : current count
module uart_sat_counter #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs received UART characters into words of word_bytes_p characters and offers them on a
// ready/valid interface. The receiver cannot be stalled, so characters arriving while a full
// word is held back are dropped (sticky overflow_o), and receive errors flush the partial word
// (counted in err_cnt_o).
// Optional: define UART_RX_PACKER_TIMEOUT_EN to flush a partial word after timeout_cycles_p
// idle cycles.
//   clk_i, reset_n_i       : clock, asynchronous active-low reset
//   rx_v_i, rx_i           : received character strobe and data
//   rx_error_i             : receive error pulse (applies to the same or next character)
//   clear_i                : clears overflow_o and err_cnt_o
//   word_v_o, word_o       : output word valid / data (first character in the low lane)
//   word_ready_i           : consumer ready
//   overflow_o             : sticky dropped-character flag
//   err_cnt_o              : saturating count of flushed partial words
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int unsigned data_bits_p      = 8,
  parameter int unsigned word_bytes_p     = 4,
  parameter int unsigned timeout_cycles_p = 1048576
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  rx_v_i,
  input  logic [data_bits_p-1:0]                rx_i,
  input  logic                                  rx_error_i,
  input  logic                                  clear_i,
  output logic                                  word_v_o,
  output logic [data_bits_p*word_bytes_p-1:0]   word_o,
  input  logic                                  word_ready_i,
  output logic                                  overflow_o,
  output logic [uart_err_cnt_width_gp-1:0]      err_cnt_o
);

  localparam int unsigned WordW = data_bits_p * word_bytes_p;
  localparam int unsigned CntW  = $clog2(word_bytes_p + 1);

  if (data_bits_p < 5 || data_bits_p > 9 || word_bytes_p < 1 || timeout_cycles_p < 1)
  begin : g_bad_params
    $error("uart_rx_word_packer: unsupported parameter values");
  end

  uart_packer_state_e state_q, state_d;
  logic [WordW-1:0]   asm_q, asm_d;
  logic [CntW-1:0]    byte_cnt_q, byte_cnt_d;
  logic               err_pend_q, err_pend_d;
  logic [WordW-1:0]   out_q, out_d;
  logic               out_v_q, out_v_d;
  logic               overflow_q, overflow_d;
  logic               drain, char_err, ovf_event, err_inc;
  logic               tmo_hit;

`ifdef UART_RX_PACKER_TIMEOUT_EN
  localparam int unsigned TmoW = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

  logic            tmo_run;
  logic [TmoW-1:0] tmo_q, tmo_d;

  assign tmo_run = (state_q == e_fill) && (byte_cnt_q != '0);
  assign tmo_hit = tmo_run && (tmo_q == TmoW'(timeout_cycles_p - 1));
  // Restart on every character, on expiry, and whenever no partial word is pending.
  assign tmo_d   = (!tmo_run || tmo_hit || rx_v_i) ? '0 : tmo_q + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign drain    = out_v_q & word_ready_i;
  assign char_err = rx_v_i & (err_pend_q | rx_error_i);

  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    err_pend_d = err_pend_q;
    out_d      = out_q;
    out_v_d    = out_v_q;
    ovf_event  = 1'b0;
    err_inc    = 1'b0;

    if (drain) begin
      out_v_d = 1'b0;
    end
    // An error pulse without a character marks the next character.
    if (rx_error_i && !rx_v_i) begin
      err_pend_d = 1'b1;
    end
    // Timeout flush happens first so a same-cycle character starts a fresh word.
    if (tmo_hit) begin
      asm_d      = '0;
      byte_cnt_d = '0;
      err_inc    = 1'b1;
    end

    unique case (state_q)
      e_fill: begin
        if (rx_v_i) begin
          err_pend_d = 1'b0;
          if (char_err) begin
            asm_d      = '0;
            byte_cnt_d = '0;
            err_inc    = 1'b1;
          end else begin
            for (int k = 0; k < int'(word_bytes_p); k++) begin
              if (byte_cnt_d == CntW'(k)) begin
                asm_d[k*data_bits_p +: data_bits_p] = rx_i;
              end
            end
            if (byte_cnt_d == CntW'(word_bytes_p - 1)) begin
              if (!out_v_q || drain) begin
                out_d      = asm_d;
                out_v_d    = 1'b1;
                asm_d      = '0;
                byte_cnt_d = '0;
              end else begin
                state_d    = e_stall;
                byte_cnt_d = CntW'(word_bytes_p);
              end
            end else begin
              byte_cnt_d = byte_cnt_d + 1'b1;
            end
          end
        end
      end
      e_stall: begin
        if (rx_v_i) begin
          ovf_event  = 1'b1;
          err_pend_d = 1'b0;
        end
        if (drain) begin
          out_d      = asm_q;
          out_v_d    = 1'b1;
          asm_d      = '0;
          byte_cnt_d = '0;
          state_d    = e_fill;
        end
      end
      default: state_d = e_fill;
    endcase
  end

  // A new overflow event beats a same-cycle clear.
  assign overflow_d = ovf_event ? 1'b1 : (clear_i ? 1'b0 : overflow_q);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_fill;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      err_pend_q <= 1'b0;
      out_q      <= '0;
      out_v_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      err_pend_q <= err_pend_d;
      out_q      <= out_d;
      out_v_q    <= out_v_d;
      overflow_q <= overflow_d;
    end
  end

  uart_sat_counter #(
    .width_p (uart_err_cnt_width_gp)
  ) u_err_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (err_inc),
    .clear_i   (clear_i),
    .count_o   (err_cnt_o)
  );

  assign word_v_o   = out_v_q;
  assign word_o     = out_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
module tb_uart_rx_word_packer;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        rx_v_i = 1'b0;
  logic [7:0]  rx_i = '0;
  logic        rx_error_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        word_v_o;
  logic [31:0] word_o;
  logic        word_ready_i = 1'b0;
  logic        overflow_o;
  logic [7:0]  err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  uart_rx_word_packer #(
    .data_bits_p      (8),
    .word_bytes_p     (4),
    .timeout_cycles_p (100)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .rx_v_i       (rx_v_i),
    .rx_i         (rx_i),
    .rx_error_i   (rx_error_i),
    .clear_i      (clear_i),
    .word_v_o     (word_v_o),
    .word_o       (word_o),
    .word_ready_i (word_ready_i),
    .overflow_o   (overflow_o),
    .err_cnt_o    (err_cnt_o)
  );

  // Stimulus helpers: called at a negedge, return at the next negedge.
  task automatic send(input logic [7:0] b, input logic err);
    rx_v_i = 1'b1; rx_i = b; rx_error_i = err;
    @(negedge clk_i);
    rx_v_i = 1'b0; rx_error_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    rx_v_i = 0; rx_error_i = 0; clear_i = 0; word_ready_i = 0;
    @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (word_v_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_word_v: got %b expected 0", word_v_o); end
    n_checks++; if (word_o !== 32'h0) begin n_fail++;
      $display("FAIL reset_word: got %h expected 00000000", word_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
    n_checks++; if (err_cnt_o !== 8'd0) begin n_fail++;
      $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_o); end
    reset_n_i = 1'b1;
    @(negedge clk_i);
    // Reset mid-word must discard the partial word.
    word_ready_i = 1'b1;
    send(8'hE1, 0); send(8'hE2, 0);
    reset_n_i = 1'b0; #1; reset_n_i = 1'b1;
    @(negedge clk_i);
    word_ready_i = 1'b1;
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'hA4A3A2A1) begin n_fail++;
      $display("FAIL reset_midword: got v=%b %h expected v=1 a4a3a2a1", word_v_o, word_o); end
  endtask

  task automatic test_basic();
    do_reset();
    word_ready_i = 1'b1;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    n_checks++; if (word_v_o !== 1'b0) begin n_fail++;
      $display("FAIL basic_early_v: got %b expected 0", word_v_o); end
    send(8'h44, 0);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h44332211) begin n_fail++;
      $display("FAIL basic_word: got v=%b %h expected v=1 44332211", word_v_o, word_o); end
    idle(1);
    n_checks++; if (word_v_o !== 1'b0) begin n_fail++;
      $display("FAIL basic_v_fall: got %b expected 0", word_v_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    word_ready_i = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h04030201) begin n_fail++;
      $display("FAIL b2b_held: got v=%b %h expected v=1 04030201", word_v_o, word_o); end
    word_ready_i = 1'b1;
    #1;
    n_checks++; if (word_o !== 32'h04030201) begin n_fail++;
      $display("FAIL b2b_first: got %h expected 04030201", word_o); end
    @(negedge clk_i);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h08070605) begin n_fail++;
      $display("FAIL b2b_second: got v=%b %h expected v=1 08070605", word_v_o, word_o); end
    @(negedge clk_i);
    n_checks++; if (word_v_o !== 1'b0) begin n_fail++;
      $display("FAIL b2b_v_fall: got %b expected 0", word_v_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++;
      $display("FAIL b2b_overflow: got %b expected 0", overflow_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    word_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 0);
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++;
      $display("FAIL ovf_set: got %b expected 1", overflow_o); end
    clear_i = 1'b1; @(negedge clk_i); clear_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", overflow_o); end
    word_ready_i = 1'b1;
    n_checks++; if (word_o !== 32'h13121110) begin n_fail++;
      $display("FAIL ovf_word1: got %h expected 13121110", word_o); end
    @(negedge clk_i);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h17161514) begin n_fail++;
      $display("FAIL ovf_word2: got v=%b %h expected v=1 17161514", word_v_o, word_o); end
    // Clear and a new overflow in the same cycle: overflow wins.
    @(negedge clk_i);
    word_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 0);
    clear_i = 1'b1;
    send(8'h99, 0);
    clear_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b1) begin n_fail++;
      $display("FAIL ovf_clear_race: got %b expected 1", overflow_o); end
  endtask

  task automatic test_error_flush();
    do_reset();
    word_ready_i = 1'b1;
    send(8'hAA, 0); send(8'hBB, 0);
    rx_error_i = 1'b1; @(negedge clk_i); rx_error_i = 1'b0;
    send(8'hCC, 0);
    n_checks++; if (err_cnt_o !== 8'd1) begin n_fail++;
      $display("FAIL err_count: got %0d expected 1", err_cnt_o); end
    n_checks++; if (word_v_o !== 1'b0) begin n_fail++;
      $display("FAIL err_no_word: got %b expected 0", word_v_o); end
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h04030201) begin n_fail++;
      $display("FAIL err_after_word: got v=%b %h expected v=1 04030201", word_v_o, word_o); end
    // Error in the same cycle as the character.
    send(8'h71, 0); send(8'h99, 1);
    n_checks++; if (err_cnt_o !== 8'd2) begin n_fail++;
      $display("FAIL err_same_cycle: got %0d expected 2", err_cnt_o); end
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 0);
    n_checks++; if (word_o !== 32'h34333231) begin n_fail++;
      $display("FAIL err_same_word: got %h expected 34333231", word_o); end
    // Error-marked character while stalled: overflow only, held word kept.
    idle(1);
    word_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), 0);
    send(8'hEE, 1);
    n_checks++; if (overflow_o !== 1'b1 || err_cnt_o !== 8'd2) begin n_fail++;
      $display("FAIL err_stall: got ovf=%b cnt=%0d expected ovf=1 cnt=2", overflow_o, err_cnt_o);
    end
    word_ready_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (word_o !== 32'h57565554) begin n_fail++;
      $display("FAIL err_stall_word: got %h expected 57565554", word_o); end
    // Pending error was consumed: next full word is clean.
    send(8'h61, 0); send(8'h62, 0); send(8'h63, 0); send(8'h64, 0);
    n_checks++; if (word_o !== 32'h64636261 || err_cnt_o !== 8'd2) begin n_fail++;
      $display("FAIL err_stall_after: got %h cnt=%0d expected 64636261 cnt=2", word_o, err_cnt_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    word_ready_i = 1'b1;
    for (int i = 0; i < 260; i++) send(8'h00, 1);
    n_checks++; if (err_cnt_o !== 8'd255) begin n_fail++;
      $display("FAIL sat_255: got %0d expected 255", err_cnt_o); end
    clear_i = 1'b1;
    send(8'h00, 1);
    clear_i = 1'b0;
    n_checks++; if (err_cnt_o !== 8'd0) begin n_fail++;
      $display("FAIL sat_clear_race: got %0d expected 0", err_cnt_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    word_ready_i = 1'b1;
    send(8'h55, 0);
`ifdef UART_RX_PACKER_TIMEOUT_EN
    idle(98);
    n_checks++; if (err_cnt_o !== 8'd0) begin n_fail++;
      $display("FAIL tmo_early: got %0d expected 0", err_cnt_o); end
    idle(4);
    n_checks++; if (err_cnt_o !== 8'd1) begin n_fail++;
      $display("FAIL tmo_flush: got %0d expected 1", err_cnt_o); end
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h04030201) begin n_fail++;
      $display("FAIL tmo_word: got v=%b %h expected v=1 04030201", word_v_o, word_o); end
`else
    idle(102);
    n_checks++; if (err_cnt_o !== 8'd0) begin n_fail++;
      $display("FAIL notmo_cnt: got %0d expected 0", err_cnt_o); end
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    n_checks++; if (word_v_o !== 1'b1 || word_o !== 32'h03020155) begin n_fail++;
      $display("FAIL notmo_word: got v=%b %h expected v=1 03020155", word_v_o, word_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_error_flush();
    test_saturation();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
Sits directly downstream of the UART receiver. It collects received characters into a word of word_bytes_p characters and presents each word on a ready/valid interface to the host/bridge logic. The UART has no back-pressure, so the block discards characters on overflow, flushes partial words on receive errors, and keeps status flags and a counter.

Parameters:
data_bits_p, 8, character width; must match the receiver (5-9).
word_bytes_p, 4, characters per output word (>=1).
timeout_cycles_p, 1048576, idle cycles before a partial word is flushed; used only with the optional feature.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous active-low reset.
rx_v_i  in  1  one-cycle strobe: character valid.
rx_i  in  data_bits_p  received character.
rx_error_i  in  1  one-cycle receive error pulse (parity/stop); may precede rx_v_i.
clear_i  in  1  synchronous clear of overflow_o and err_cnt_o.
word_v_o  out  1  output word valid.
word_o  out  data_bits_p*word_bytes_p  packed word; first character in bits [data_bits_p-1:0].
word_ready_i  in  1  consumer ready; a transfer occurs when word_v_o & word_ready_i.
overflow_o  out  1  sticky: at least one character was dropped.
err_cnt_o  out  8  saturating count of flushed partial words (errors and timeouts).

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert) clears everything:
  - state=e_fill; word_v_o=0; word_o=0; overflow_o=0; err_cnt_o=0.
  - Assembly register, byte count, error-pending flag and timeout counter all 0.
- Reset mid-word discards all partial and held data.
- Packing:
  - An accepted character is written to lane byte_cnt (lane k = bits [k*data_bits_p +: data_bits_p]).
  - byte_cnt increments and is sized clog2(word_bytes_p+1).
- States:
  - e_fill: accept characters. When the last character (byte_cnt==word_bytes_p-1) is accepted:
    - If the output register is empty or being drained this cycle: load the output register; word_v_o rises the next cycle. byte_cnt goes to 0 and the state stays e_fill.
    - Otherwise go to e_stall holding the completed word.
  - e_stall: the assembly register is full. On word_ready_i & word_v_o, move the assembly word to the output register in the same cycle (back-to-back words possible) and return to e_fill.
    - Any rx_v_i received in e_stall is dropped and sets overflow_o.
- Latency: word_v_o asserts exactly 1 cycle after the rx_v_i carrying the final character, if the output path is free.
- word_o is stable while word_v_o=1 and not consumed. word_v_o falls the cycle after the transfer unless it is reloaded.
- Errors:
  - rx_error_i sets error_pending.
  - The next rx_v_i with error_pending=1 is discarded, the partial word is flushed (byte_cnt=0, lanes zeroed), err_cnt_o increments, and error_pending clears.
  - If rx_error_i and rx_v_i occur in the same cycle, the error applies to that character.
  - In e_stall, an error-marked character is dropped and sets overflow_o only. The held word is not flushed, but error_pending still clears.
- Counter and flags:
  - err_cnt_o saturates at 255.
  - If clear_i and an increment occur in the same cycle, clear wins (result 0).
  - If clear_i and an overflow event occur in the same cycle, overflow_o=1 (the new event wins).

Optional Feature:
UART_RX_PACKER_TIMEOUT_EN:
- Defined:
  - A counter runs while in e_fill with byte_cnt>0 and resets on each accepted character.
  - On reaching timeout_cycles_p-1, the partial word is flushed and err_cnt_o increments.
  - A character arriving in the same cycle as the timeout is treated as the first character of a new word.
- Undefined: no counter exists; a partial word persists indefinitely.

Decomposition:
- Shared package uart_pkg:
  - State enum uart_packer_state_e {e_fill, e_stall}.
  - Constant uart_err_cnt_width_gp=8.
- Sub-module uart_sat_counter (width parameter; inc_i, clear_i, count_o; saturating; clear priority) is used for err_cnt_o and is reusable by the transmit side.
- All other logic is inline.

Test Plan:
- Basic packing (word_bytes_p=4, ready=1): bytes 0x11,0x22,0x33,0x44 -> word_o=0x44332211, word_v_o high for 1 cycle, starting the cycle after the 4th rx_v_i.
- Back-pressure (ready=0): 8 bytes 0x01..0x08 -> first word 0x04030201 held. Second word enters e_stall. Raise ready -> 0x04030201 then 0x08070605 on consecutive cycles, overflow_o=0.
- Overflow: hold ready=0 and send 9 bytes -> 9th byte dropped, overflow_o=1. clear_i -> overflow_o=0, and the held words remain intact.
- Error flush: 0xAA,0xBB, then rx_error_i pulse, then 0xCC -> err_cnt_o=1, byte_cnt=0. Then 0x01..0x04 -> word 0x04030201.
- Saturation: 260 error flushes -> err_cnt_o=255. clear_i with a simultaneous error -> err_cnt_o=0.
- Timeout (feature on, timeout_cycles_p=100): 0x55, idle 100 cycles -> partial flushed, err_cnt_o=1. Then 4 bytes -> correct word. With the feature off, the same stimulus gives err_cnt_o=0 and word 0x03020155 after bytes 0x01..0x03.
